btn_repeat_ctrl: RTL
====================

Name: btn_repeat_ctrl

Overview:
- Consumes the 20 Hz toggling slow-clock signal produced by the clock-divider stage. Uses it as a sample tick to debounce one raw pushbutton.
- Produces single-cycle press pulses, with hold-to-auto-repeat, for the OLED/UI logic.
- Runs entirely in the basys_clk domain. The slow signal is treated as data, never as a clock.

Parameters:
- DEBOUNCE_TICKS, 2: consecutive equal samples needed to accept a press or release. Legal range 2..15.
- REPEAT_DELAY, 10: ticks held after acceptance before the first repeat (10 ticks = 500 ms at 20 Hz). Legal range 1..255.
- REPEAT_RATE, 2: ticks between subsequent repeats. Legal range 1..255.

Ports:
- basys_clk  input  1  system clock, 100 MHz
- reset_n  input  1  asynchronous active-low reset
- tick_src  input  1  20 Hz toggling signal from the divider; each rising edge is one sample tick
- btn_raw  input  1  raw pushbutton, asynchronous
- press_pulse  output  1  one-cycle pulse on accepted press and on each auto-repeat
- release_pulse  output  1  one-cycle pulse on accepted release
- btn_held  output  1  debounced button level
- repeat_count  output  8  number of repeats since the last accepted press; saturates at 255

Behaviour:
- Reset: asynchronous, active-low. Clears all registers immediately: synchronisers, FSM to IDLE, counters, and all outputs to 0. No release_pulse is issued on reset, including reset mid-press.
- Synchronisers: btn_raw and tick_src each pass through a 2-FF synchroniser (btn_s, tick_s2).
- Tick detect: tick_q <= tick_s2; tick = tick_s2 & ~tick_q. The FSM acts only on cycles where tick=1 and otherwise holds state.
- Latency: with tick_src rising before basys_clk edge k, tick is high between edges k+1 and k+2. Outputs update at edge k+2, so press_pulse/release_pulse are high for exactly the cycle after edge k+2.
- Counters: deb_cnt is 4 bits; timer is 8 bits.
- FSM states: IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE.
- IDLE, on tick:
  - btn_s=1: go to DEB_PRESS, deb_cnt<=1.
  - otherwise: stay.
- DEB_PRESS, on tick:
  - btn_s=0: go to IDLE.
  - btn_s=1: deb_cnt+1. When it equals DEBOUNCE_TICKS: go to HELD, press_pulse=1, timer<=0, repeat_count<=0.
- HELD, on tick:
  - btn_s=0: go to DEB_RELEASE, deb_cnt<=1.
  - btn_s=1: timer+1. When it equals REPEAT_DELAY: go to REPEAT, press_pulse=1, repeat_count+1 (saturating), timer<=0.
- REPEAT, on tick:
  - btn_s=0: go to DEB_RELEASE, deb_cnt<=1.
  - btn_s=1: timer+1. When it equals REPEAT_RATE: press_pulse=1, repeat_count+1 (saturating), timer<=0.
- DEB_RELEASE, on tick:
  - btn_s=1: go to HELD with timer<=0 and no pulse. The full REPEAT_DELAY is re-waited; repeat_count is kept.
  - btn_s=0: deb_cnt+1. When it equals DEBOUNCE_TICKS: go to IDLE, release_pulse=1.
- btn_held: registered; 1 exactly while state is HELD, REPEAT or DEB_RELEASE.
- repeat_count: holds its value after release until the next accepted press. At 255, further repeats still pulse press_pulse; the count stays at 255.
- Pulse exclusivity: press_pulse and release_pulse are never high in the same cycle. Each pulse lasts exactly one basys_clk cycle.
- btn_raw changes between ticks: ignored; only the value at each tick cycle matters.
- tick_src stuck high or low: no ticks are generated, so the FSM and outputs are frozen.
- Verification ticks: the bench may drive tick_src with any period ≥ 8 basys_clk cycles; behaviour is counted in ticks, not time.

Test Plan:
(defaults; bench drives tick_src with a 20-cycle period)
- Reset: assert reset_n=0 for 5 cycles, then release with btn_raw=0 and 10 ticks -> all outputs stay 0.
- Glitch rejection: btn_raw=1 for 1 tick sample, then 0 -> no press_pulse, btn_held=0, FSM back in IDLE.
- Clean press: btn_raw=1 for 5 ticks, then 0 for 3 ticks:
  - press_pulse exactly once, on 2nd high tick (3 cycles after that tick_src edge); btn_held=1.
  - release_pulse once, on 2nd low tick; repeat_count=0.
- Auto-repeat: hold btn_raw=1 for 20 ticks -> press_pulse on ticks 2, 12, 14, 16, 18, 20 (6 total); repeat_count=5 after tick 20 and retained after release.
- Release bounce: after HELD, btn low for 1 tick then high:
  - no release_pulse; btn_held stays 1.
  - next repeat is exactly 10 ticks after the return to HELD.
- Reset and saturation:
  - reset_n=0 mid-REPEAT -> all outputs 0 immediately, no release_pulse.
  - With REPEAT_DELAY=1, REPEAT_RATE=1, hold 300 ticks -> repeat_count=255, press_pulse still firing every tick.

Source files
------------

// File: rtl/btn_repeat_ctrl_if.sv
// Button/tick inputs and debounced pulse outputs of btn_repeat_ctrl.
// master: the side that supplies tick and button and consumes the pulses.
// slave:  the controller itself.
interface btn_repeat_ctrl_if;
  logic       tick_src;
  logic       btn_raw;
  logic       press_pulse;
  logic       release_pulse;
  logic       btn_held;
  logic [7:0] repeat_count;

  modport master (
    output tick_src, btn_raw,
    input  press_pulse, release_pulse, btn_held, repeat_count
  );

  modport slave (
    input  tick_src, btn_raw,
    output press_pulse, release_pulse, btn_held, repeat_count
  );
endinterface

// File: rtl/btn_repeat_ctrl.sv
// Pushbutton debouncer with hold-to-auto-repeat.
// The divider's slow toggling signal is synchronised and edge-detected into a
// one-cycle sample tick. The FSM only advances on tick cycles, so all timing
// is counted in ticks. Everything runs on basys_clk.
module btn_repeat_ctrl #(
  parameter int DEBOUNCE_TICKS = 2,   // 2..15
  parameter int REPEAT_DELAY   = 10,  // 1..255
  parameter int REPEAT_RATE    = 2    // 1..255
) (
  input  logic                basys_clk,
  input  logic                reset_n,
  btn_repeat_ctrl_if.slave    io
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  localparam logic [3:0] DEB_TGT  = 4'(DEBOUNCE_TICKS);
  localparam logic [7:0] DLY_TGT  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_TGT = 8'(REPEAT_RATE);

  logic btn_s1, btn_s;
  logic tick_s1, tick_s2, tick_q;
  logic tick;

  state_t     state_q, state_nxt;
  logic [3:0] deb_cnt, deb_nxt;
  logic [7:0] timer, timer_nxt;
  logic [7:0] rep_cnt, rep_nxt;
  logic       press_q, press_nxt;
  logic       release_q, release_nxt;
  logic       held_q, held_nxt;

  logic [3:0] deb_inc;
  logic [7:0] timer_inc;
  logic [7:0] rep_inc;

  // Two-stage synchronisers for both asynchronous inputs, plus the tick
  // edge-detect register.
  // NOTE: non-blocking assignments make each stage sample the previous
  // stage's old value; blocking ones would collapse the chain into one flop.
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1  <= 1'b0;
      btn_s   <= 1'b0;
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      btn_s1  <= io.btn_raw;
      btn_s   <= btn_s1;
      tick_s1 <= io.tick_src;
      tick_s2 <= tick_s1;
      tick_q  <= tick_s2;
    end
  end

  assign tick = tick_s2 & ~tick_q;

  assign deb_inc   = deb_cnt + 4'd1;
  assign timer_inc = timer + 8'd1;
  assign rep_inc   = (rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1;

  // Next-state and registered-output logic; only tick cycles change anything.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state_q;
    deb_nxt     = deb_cnt;
    timer_nxt   = timer;
    rep_nxt     = rep_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_nxt = DEB_PRESS;
            deb_nxt   = 4'd1;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state_nxt = IDLE;
          end else if (deb_inc == DEB_TGT) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
            timer_nxt = 8'd0;
            rep_nxt   = 8'd0;
          end else begin
            deb_nxt = deb_inc;
          end
        end
        HELD, REPEAT: begin
          if (!btn_s) begin
            state_nxt = DEB_RELEASE;
            deb_nxt   = 4'd1;
          end else if (timer_inc == ((state_q == HELD) ? DLY_TGT : RATE_TGT)) begin
            state_nxt = REPEAT;
            press_nxt = 1'b1;
            rep_nxt   = rep_inc;
            timer_nxt = 8'd0;
          end else begin
            timer_nxt = timer_inc;
          end
        end
        DEB_RELEASE: begin
          // A bounce back to pressed restarts the full initial delay.
          if (btn_s) begin
            state_nxt = HELD;
            timer_nxt = 8'd0;
          end else if (deb_inc == DEB_TGT) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else begin
            deb_nxt = deb_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    held_nxt = (state_nxt == HELD) || (state_nxt == REPEAT) ||
               (state_nxt == DEB_RELEASE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      deb_cnt   <= 4'd0;
      timer     <= 8'd0;
      rep_cnt   <= 8'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      deb_cnt   <= deb_nxt;
      timer     <= timer_nxt;
      rep_cnt   <= rep_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      held_q    <= held_nxt;
    end
  end

  assign io.press_pulse   = press_q;
  assign io.release_pulse = release_q;
  assign io.btn_held      = held_q;
  assign io.repeat_count  = rep_cnt;

endmodule
